inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Parametrised successor to the single-instruction fetch stage: owns the PC, runs a one-outstanding-request fetch FSM to the memory controller, and buffers fetched {inst, pc} pairs in a DEPTH-entry circular queue that feeds the issue stage.
- Adds flush-on-redirect with in-flight response dropping, an external fetch stall for unresolved JALR, and occupancy status.
- Sits between the memory controller and the decoder/issue logic.

Parameters:
- XLEN, 32, instruction and PC width.
- DEPTH, 8, number of queue entries; must be a power of two and ≥2.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global enable; when low, all state is frozen.
- _clear  in  1  pipeline flush or redirect.
- _redirect_pc  in  XLEN  new PC; sampled when _clear is high.
- _fetch_stall  in  1  blocks new memory requests; does not block dequeue.
- _mem_req  out  1  fetch request; level signal, held until response.
- _mem_addr  out  XLEN  fetch address; stable while _mem_req is high.
- _inst_ready_in  in  1  one-cycle response strobe from memory.
- _inst_in  in  XLEN  instruction data; valid with _inst_ready_in.
- _deq_ready  in  1  consumer accepts the head entry.
- _deq_valid  out  1  queue is non-empty.
- _deq_inst  out  XLEN  head instruction.
- _deq_pc  out  XLEN  head instruction address.
- _count  out  $clog2(DEPTH)+1  current occupancy.
- _full  out  1  _count == DEPTH.

Behaviour:
- Reset (rst_in==0 at posedge):
  - pc=RESET_PC; head=tail=count=0; FSM=IDLE.
  - _mem_req=0, _mem_addr=RESET_PC, _deq_valid=0, _count=0, _full=0.
  - _deq_inst/_deq_pc=0 while the queue is empty.
- rdy_in low: no state changes. Memory must not strobe _inst_ready_in while rdy_in is low.
- FSM states are IDLE, WAIT, DROP.
- IDLE → WAIT:
  - Condition: !_clear && !_fetch_stall && count_after_pop < DEPTH.
  - Action: assert _mem_req with _mem_addr=pc from the next cycle. This reserves one queue slot.
- WAIT, on _inst_ready_in:
  - Push {_inst_in, pc} at tail; pc <= pc+4; go to IDLE.
  - Request latency is at least 2 cycles per instruction; there is no back-to-back chaining.
- WAIT, on _clear without _inst_ready_in: go to DROP; _mem_req stays high until the response arrives.
- DROP, on _inst_ready_in: discard the data; go to IDLE. A _clear while in DROP only updates pc.
- _clear (all states):
  - Queue flushed next cycle: head=tail=count=0.
  - pc <= _redirect_pc.
  - Takes priority over a same-cycle push and pop. Same-cycle _clear and _inst_ready_in in WAIT: discard the data, go to IDLE.
- Dequeue:
  - A pop happens when _deq_valid && _deq_ready && !_clear.
  - The head advances modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged; pointers wrap independently.
- Queue outputs:
  - _deq_inst/_deq_pc are combinational from the head entry.
  - _count/_full are registered occupancy.
  - Overflow cannot occur because of the slot reservation. A push while count==DEPTH is an assertion failure.
- Arithmetic: pc+4 wraps modulo 2^XLEN. Low two PC bits are not checked.
- _fetch_stall in WAIT has no effect; the outstanding request completes normally.

Optional Feature:
- Macro: IFQ_JAL_PREDECODE_EN.
- With it: a fetched instruction with opcode 7'b1101111 (JAL) sets pc <= pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}) instead of pc+4.
  - Adds output _deq_pred_taken (1 bit) per entry, set for JAL entries.
- Without it: pc always advances by 4, and the _deq_pred_taken port is absent.

Decomposition:
- Shared package (fetch_pkg):
  - Opcode constant OPC_JAL.
  - FSM state encoding IFQ_IDLE/IFQ_WAIT/IFQ_DROP (2 bits).
  - Entry width constant (2*XLEN plus 1 when predecode is enabled).
- One natural sub-module, ifq_ring_buffer: a parametrised circular buffer with push, pop, flush, count and full, instantiated once.
- FSM and PC logic live in the top.

Test Plan:
- Reset then run: memory answers 3 cycles after each request with inst=0x00000013 → _deq_pc sequence 0x0, 0x4, 0x8; _count increments to 8 and _full=1 with _deq_ready=0; no _mem_req while full.
- Full queue with _deq_ready=1 for 1 cycle → _count 8→7; next fetch to 0x20 issued next cycle.
- _clear with _redirect_pc=0x100 while in WAIT (response 2 cycles later) → response dropped, queue empty, next _mem_addr=0x100, first _deq_pc=0x100.
- _clear and _inst_ready_in in the same cycle → no push; _count=0; next _mem_addr=_redirect_pc.
- _fetch_stall held for 10 cycles in IDLE → _mem_req stays 0 and the queue drains by dequeue; release → request at the held pc.
- IFQ_JAL_PREDECODE_EN: inst 0x0100006F (jal x0,+16) fetched at pc 0x40 → next _mem_addr=0x50; the entry has _deq_pred_taken=1.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared opcode, FSM encoding and queue entry sizing for the
//            instruction fetch queue. Optional macro: IFQ_JAL_PREDECODE_EN.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

   localparam logic [6:0] OPC_JAL = 7'b1101111;

   typedef enum logic [1:0] {
      IFQ_IDLE = 2'd0,
      IFQ_WAIT = 2'd1,
      IFQ_DROP = 2'd2
   } ifq_state_e;

`ifdef IFQ_JAL_PREDECODE_EN
   localparam int IFQ_PRED_W = 1;
`else
   localparam int IFQ_PRED_W = 0;
`endif

   // Entry layout is {pred_taken (optional), inst, pc}
   function automatic int ifq_entry_w(input int xlen);
      return 2 * xlen + IFQ_PRED_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ifq_ring_buffer
// Brief    : Power-of-two circular buffer with push, pop, flush and occupancy.
// Revision : 1.0
// ============================================================================
module ifq_ring_buffer #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   en_in,
   input  logic                   flush_in,
   input  logic                   push_in,
   input  logic [WIDTH-1:0]       push_data_in,
   input  logic                   pop_in,
   output logic [WIDTH-1:0]       head_data_out,
   output logic [$clog2(DEPTH):0] count_out,
   output logic                   full_out,
   output logic                   empty_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_out      = (count_q == DEPTH_C);
   assign empty_out     = (count_q == '0);
   assign count_out     = count_q;
   assign head_data_out = mem_q[head_q];
   assign do_push       = en_in && push_in && !flush_in;
   assign do_pop        = en_in && pop_in && !flush_in && !empty_out;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (en_in && flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) tail_d = tail_q + PW'(1);
         if (do_pop)  head_d = head_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked by the owner while empty
   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[tail_q] <= push_data_in;
   end

   a_no_overflow : assert property (@(posedge clk_in) disable iff (!rst_in)
      !(do_push && full_out));

endmodule
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : PC owner, single-outstanding fetch FSM and DEPTH-entry queue of
//            fetched {inst, pc}. Optional macro: IFQ_JAL_PREDECODE_EN.
// Revision : 1.0
// ============================================================================
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 8,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   _clear,
   input  logic [XLEN-1:0]        _redirect_pc,
   input  logic                   _fetch_stall,
   output logic                   _mem_req,
   output logic [XLEN-1:0]        _mem_addr,
   input  logic                   _inst_ready_in,
   input  logic [XLEN-1:0]        _inst_in,
   input  logic                   _deq_ready,
   output logic                   _deq_valid,
   output logic [XLEN-1:0]        _deq_inst,
   output logic [XLEN-1:0]        _deq_pc,
   output logic [$clog2(DEPTH):0] _count,
`ifdef IFQ_JAL_PREDECODE_EN
   output logic                   _deq_pred_taken,
`endif
   output logic                   _full
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = ifq_entry_w(XLEN);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

   ifq_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic            mem_req_q, mem_req_d;
   logic [XLEN-1:0] next_pc;
   logic            push;
   logic            pop;
   logic            empty;
   logic [CW-1:0]   count_after_pop;
   logic [EW-1:0]   push_entry;
   logic [EW-1:0]   head_entry;

   assign pop             = !empty && _deq_ready && !_clear;
   assign push            = (state_q == IFQ_WAIT) && _inst_ready_in && !_clear;
   assign count_after_pop = _count - {{(CW-1){1'b0}}, pop};

`ifdef IFQ_JAL_PREDECODE_EN
   logic            is_jal;
   logic [XLEN-1:0] jal_off;
   assign is_jal  = (_inst_in[6:0] == OPC_JAL);
   assign jal_off = {{(XLEN-21){_inst_in[31]}}, _inst_in[31], _inst_in[19:12],
                     _inst_in[20], _inst_in[30:21], 1'b0};
   assign next_pc         = is_jal ? (pc_q + jal_off) : (pc_q + PC_STEP);
   assign push_entry      = {is_jal, _inst_in, pc_q};
   assign _deq_pred_taken = _deq_valid && head_entry[2*XLEN];
`else
   assign next_pc    = pc_q + PC_STEP;
   assign push_entry = {_inst_in, pc_q};
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      case (state_q)
         IFQ_IDLE: begin
            // Issuing only when a slot is free reserves it for the response
            if (!_clear && !_fetch_stall && (count_after_pop < DEPTH_C)) begin
               state_d    = IFQ_WAIT;
               mem_req_d  = 1'b1;
               mem_addr_d = pc_q;
            end
         end
         IFQ_WAIT: begin
            if (_inst_ready_in) begin
               state_d   = IFQ_IDLE;
               mem_req_d = 1'b0;
               if (!_clear) pc_d = next_pc;
            end else if (_clear) begin
               state_d = IFQ_DROP;
            end
         end
         IFQ_DROP: begin
            if (_inst_ready_in) begin
               state_d   = IFQ_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = IFQ_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
      if (_clear) pc_d = _redirect_pc;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q    <= IFQ_IDLE;
         pc_q       <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
      end else if (rdy_in) begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   ifq_ring_buffer #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .en_in         (rdy_in),
      .flush_in      (_clear),
      .push_in       (push),
      .push_data_in  (push_entry),
      .pop_in        (pop),
      .head_data_out (head_entry),
      .count_out     (_count),
      .full_out      (_full),
      .empty_out     (empty)
   );

   assign _mem_req   = mem_req_q;
   assign _mem_addr  = mem_addr_q;
   assign _deq_valid = !empty;
   assign _deq_inst  = _deq_valid ? head_entry[2*XLEN-1:XLEN] : '0;
   assign _deq_pc    = _deq_valid ? head_entry[XLEN-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Brief    : Self-checking bench for inst_fetch_queue against a queue-based
//            reference model. Optional macro: IFQ_JAL_PREDECODE_EN.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch_queue;

   localparam int DEPTH = 8;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      bit          pred;
   } ent_t;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        fetch_stall = 1'b0;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_in = '0;
   logic        deq_ready = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        deq_valid;
   logic [31:0] deq_inst;
   logic [31:0] deq_pc;
   logic [3:0]  count;
   logic        full;
`ifdef IFQ_JAL_PREDECODE_EN
   logic        pred_taken;
`endif

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   ent_t        q[$];
   logic [31:0] m_pc, m_addr, m_inst;
   bit          m_out, m_drop;
   int          m_wait, m_lat;
   int          lat_cfg = 2;
   bit          rand_inst = 1'b0;
   bit          use_force = 1'b0;
   logic [31:0] force_inst = 32'h0;

   inst_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      ._clear         (clear),
      ._redirect_pc   (redirect_pc),
      ._fetch_stall   (fetch_stall),
      ._mem_req       (mem_req),
      ._mem_addr      (mem_addr),
      ._inst_ready_in (inst_ready),
      ._inst_in       (inst_in),
      ._deq_ready     (deq_ready),
      ._deq_valid     (deq_valid),
      ._deq_inst      (deq_inst),
      ._deq_pc        (deq_pc),
      ._count         (count),
`ifdef IFQ_JAL_PREDECODE_EN
      ._deq_pred_taken(pred_taken),
`endif
      ._full          (full)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end

   function automatic bit is_jal(input logic [31:0] i);
`ifdef IFQ_JAL_PREDECODE_EN
      return i[6:0] == 7'b1101111;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] i);
      logic [31:0] off;
      off = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      return is_jal(i) ? pc + off : pc + 32'd4;
   endfunction

   task automatic do_reset();
      rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; fetch_stall = 1'b0;
      deq_ready = 1'b0; inst_ready = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      q.delete();
      m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0;
      m_out = 1'b0; m_drop = 1'b0; m_wait = 0; m_lat = 0;
   endtask

   // One clock of stimulus; the memory responder and the model live here.
   task automatic step(input bit rdy, input bit clr, input logic [31:0] redir,
                       input bit stall, input bit drdy);
      bit          resp, pop, issue;
      logic [31:0] inst, old_pc, r;
      ent_t        e;
      resp = rdy && m_out && (m_wait >= m_lat);
      inst = m_inst;
      r = $urandom;
      rdy_in = rdy; clear = clr; redirect_pc = redir; fetch_stall = stall;
      deq_ready = drdy; inst_ready = resp; inst_in = resp ? inst : r;
      @(posedge clk_in);
      #1;
      inst_ready = 1'b0;
      if (rdy) begin
         old_pc = m_pc;
         pop    = (q.size() != 0) && drdy && !clr;
         issue  = !m_out && !clr && !stall && ((q.size() - int'(pop)) < DEPTH);
         if (clr) begin
            q.delete();
            m_pc = redir;
         end else begin
            if (pop) void'(q.pop_front());
            if (resp && !m_drop) begin
               e.inst = inst; e.pc = m_pc; e.pred = is_jal(inst);
               q.push_back(e);
               m_pc = model_next_pc(m_pc, inst);
            end
         end
         if (m_out) begin
            if (resp) begin
               m_out = 1'b0; m_drop = 1'b0;
            end else begin
               if (clr) m_drop = 1'b1;
               m_wait++;
            end
         end else if (issue) begin
            m_out  = 1'b1; m_drop = 1'b0; m_addr = old_pc; m_wait = 0;
            m_lat  = (lat_cfg < 0) ? int'($urandom_range(4, 0)) : lat_cfg;
            r      = $urandom;
            m_inst = rand_inst ? ((r & ~32'h7F) | 32'h13) : (use_force ? force_inst : 32'h13);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
      vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL reset_deq_valid got %0b want 0", deq_valid); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
      vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0b want 0", full); end
      vectors++; if (deq_pc !== 32'h0 || deq_inst !== 32'h0) begin miscompares++; $display("FAIL reset_deq_data got %h/%h want 0/0", deq_pc, deq_inst); end
      repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL frozen_mem_req got %0b want 0", mem_req); end
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL first_req got %0b@%h want 1@0", mem_req, mem_addr); end
   endtask

   task automatic test_fill();
      do_reset();
      lat_cfg = 2; rand_inst = 1'b0;
      for (int k = 0; k < 300 && q.size() < DEPTH; k++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         vectors++; if (count !== 4'(q.size())) begin miscompares++; $display("FAIL fill_count got %0d want %0d", count, q.size()); end
         vectors++; if (mem_req !== m_out || (m_out && mem_addr !== m_addr)) begin miscompares++; $display("FAIL fill_req got %0b@%h want %0b@%h", mem_req, mem_addr, m_out, m_addr); end
      end
      vectors++; if (count !== 4'd8 || full !== 1'b1) begin miscompares++; $display("FAIL fill_full got count=%0d full=%0b want 8/1", count, full); end
      vectors++; if (deq_pc !== 32'h0 || deq_inst !== 32'h13) begin miscompares++; $display("FAIL fill_head got %h/%h want 0/13", deq_pc, deq_inst); end
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL full_no_req got %0b want 0", mem_req); end
      end
   endtask

   task automatic test_drain_one();
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      vectors++; if (count !== 4'd7 || full !== 1'b0) begin miscompares++; $display("FAIL pop_count got %0d/%0b want 7/0", count, full); end
      vectors++; if (deq_pc !== 32'h4) begin miscompares++; $display("FAIL pop_head got %h want 4", deq_pc); end
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin miscompares++; $display("FAIL refetch got %0b@%h want 1@20", mem_req, mem_addr); end
      for (int k = 0; k < 20 && q.size() < DEPTH; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL refill_full got %0b want 1", full); end
      for (int i = 0; i < DEPTH; i++) begin
         vectors++; if (deq_pc !== 32'(4 * (i + 1))) begin miscompares++; $display("FAIL drain_pc[%0d] got %h want %h", i, deq_pc, 4 * (i + 1)); end
         step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      end
      vectors++; if (count !== 4'd0 || deq_valid !== 1'b0 || deq_pc !== 32'h0) begin miscompares++; $display("FAIL drained got count=%0d valid=%0b pc=%h want 0/0/0", count, deq_valid, deq_pc); end
   endtask

   task automatic test_clear_wait();
      do_reset();
      lat_cfg = 3; rand_inst = 1'b0;
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
      for (int k = 0; k < 20 && m_out; k++) begin
         vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL drop_req_held got %0b@%h want 1@0", mem_req, mem_addr); end
         step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      end
      vectors++; if (count !== 4'd0 || deq_valid !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL dropped got count=%0d valid=%0b req=%0b want 0/0/0", count, deq_valid, mem_req); end
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL redirect_req got %0b@%h want 1@100", mem_req, mem_addr); end
      for (int k = 0; k < 20 && q.size() == 0; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++; if (deq_valid !== 1'b1 || deq_pc !== 32'h100 || deq_inst !== 32'h13) begin miscompares++; $display("FAIL redirect_head got %0b %h/%h want 1 100/13", deq_valid, deq_pc, deq_inst); end
   endtask

   task automatic test_clear_same_cycle();
      do_reset();
      lat_cfg = 1; rand_inst = 1'b0;
      for (int k = 0; k < 40 && q.size() < 2; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 20 && !(m_out && m_wait >= m_lat); k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1);
      vectors++; if (count !== 4'd0 || deq_valid !== 1'b0) begin miscompares++; $display("FAIL clr_resp_queue got count=%0d valid=%0b want 0/0", count, deq_valid); end
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL clr_resp_req got %0b want 0", mem_req); end
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin miscompares++; $display("FAIL clr_resp_next got %0b@%h want 1@200", mem_req, mem_addr); end
   endtask

   task automatic test_fetch_stall();
      do_reset();
      lat_cfg = 1; rand_inst = 1'b0;
      for (int k = 0; k < 60 && !(q.size() == 3 && !m_out); k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
         vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req got %0b want 0", mem_req); end
         vectors++; if (count !== 4'(q.size())) begin miscompares++; $display("FAIL stall_count got %0d want %0d", count, q.size()); end
      end
      vectors++; if (count !== 4'd0 || deq_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain got count=%0d valid=%0b want 0/0", count, deq_valid); end
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'hC) begin miscompares++; $display("FAIL stall_release got %0b@%h want 1@c", mem_req, mem_addr); end
   endtask

   task automatic test_random();
      logic [31:0] r;
      bit          ev;
      do_reset();
      lat_cfg = -1; rand_inst = 1'b1;
      for (int k = 0; k < 500; k++) begin
         r = $urandom;
         r[1:0] = 2'b00;
         step($urandom_range(7, 0) != 0, $urandom_range(19, 0) == 0, r,
              $urandom_range(5, 0) == 0, $urandom_range(1, 0) == 1);
         ev = (q.size() != 0);
         vectors++; if (mem_req !== m_out) begin miscompares++; $display("FAIL rnd_req[%0d] got %0b want %0b", k, mem_req, m_out); end
         vectors++; if (mem_addr !== m_addr) begin miscompares++; $display("FAIL rnd_addr[%0d] got %h want %h", k, mem_addr, m_addr); end
         vectors++; if (count !== 4'(q.size()) || full !== (q.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_count[%0d] got %0d/%0b want %0d", k, count, full, q.size()); end
         vectors++; if (deq_valid !== ev) begin miscompares++; $display("FAIL rnd_valid[%0d] got %0b want %0b", k, deq_valid, ev); end
         vectors++; if (deq_pc !== (ev ? q[0].pc : 32'h0)) begin miscompares++; $display("FAIL rnd_pc[%0d] got %h want %h", k, deq_pc, ev ? q[0].pc : 32'h0); end
         vectors++; if (deq_inst !== (ev ? q[0].inst : 32'h0)) begin miscompares++; $display("FAIL rnd_inst[%0d] got %h want %h", k, deq_inst, ev ? q[0].inst : 32'h0); end
`ifdef IFQ_JAL_PREDECODE_EN
         vectors++; if (pred_taken !== (ev && q[0].pred)) begin miscompares++; $display("FAIL rnd_pred[%0d] got %0b", k, pred_taken); end
`endif
      end
   endtask

`ifdef IFQ_JAL_PREDECODE_EN
   task automatic test_jal();
      do_reset();
      lat_cfg = 1; rand_inst = 1'b0; use_force = 1'b1; force_inst = 32'h0100006F;
      step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      use_force = 1'b0;
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin miscompares++; $display("FAIL jal_req got %0b@%h want 1@40", mem_req, mem_addr); end
      for (int k = 0; k < 20 && q.size() == 0; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++; if (pred_taken !== 1'b1 || deq_pc !== 32'h40 || deq_inst !== 32'h0100006F) begin miscompares++; $display("FAIL jal_entry got %0b %h/%h want 1 40/0100006f", pred_taken, deq_pc, deq_inst); end
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h50) begin miscompares++; $display("FAIL jal_target got %0b@%h want 1@50", mem_req, mem_addr); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_drain_one();
      test_clear_wait();
      test_clear_same_cycle();
      test_fetch_stall();
`ifdef IFQ_JAL_PREDECODE_EN
      test_jal();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
